// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer that drives the 34-bit corelet instruction word
// through a full convolution run: per kij pass it loads a weight tile into
// the PE array, streams the activations, executes, drains, and copies the
// OFIFO rows into pmem; after all passes it reads pmem back in accumulate
// order (output index outer, kij inner).
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        run request, honoured only in IDLE
//   mode         WS(0)/OS(1), captured with an accepted start
//   ofifo_valid  OFIFO has a row available
//   inst         registered instruction word
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the DONE state
//
// Timing model: inst_q is loaded from the next-state values, so the word on
// inst always describes the cycle the FSM is currently in. l0_wr and acc are
// the registered "a read was issued last cycle" flags taken from inst_q.
// In O_RD the write shown in a cycle is the response to ofifo_valid sampled
// at the edge that opened that cycle.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int ACT_LEN = 16,
  parameter int NKIJ    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, W_XFER, W_LOAD, A_XFER, EXEC, DRAIN, O_RD, ACC, DONE
  } state_t;

  localparam int IW = 16;
  localparam int KW = 8;

  localparam logic [IW-1:0] W_LAST = IW'(row - 1);
  localparam logic [IW-1:0] L_LAST = IW'(row + col - 1);
  localparam logic [IW-1:0] A_LAST = IW'(ACT_LEN - 1);
  localparam logic [IW-1:0] A_CNT  = IW'(ACT_LEN);
  localparam logic [IW-1:0] ROW_N  = IW'(row);
  localparam logic [KW-1:0] K_LAST = KW'(NKIJ - 1);

  // CEN_pmem, WEN_pmem, CEN_xmem, WEN_xmem high; everything else low
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic            mode_q, mode_d;
  logic [33:0]     inst_q, inst_d;
  logic            owr;   // O_RD write issued in the next cycle
  logic [IW-1:0]   widx;  // index of that write within the pass

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      mode_q  <= 1'b0;
      inst_q  <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    mode_d  = mode_q;
    owr     = 1'b0;
    widx    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = W_XFER;
          mode_d  = mode;
          k_d     = '0;
          i_d     = '0;
        end
      end
      W_XFER: begin
        if (i_q == W_LAST) begin
          state_d = W_LOAD;
          i_d     = '0;
        end else i_d = i_q + 1'b1;
      end
      W_LOAD: begin
        if (i_q == L_LAST) begin
          state_d = A_XFER;
          i_d     = '0;
        end else i_d = i_q + 1'b1;
      end
      A_XFER: begin
        if (i_q == A_LAST) begin
          state_d = EXEC;
          i_d     = '0;
        end else i_d = i_q + 1'b1;
      end
      EXEC: begin
        if (i_q == A_LAST) begin
          state_d = DRAIN;
          i_d     = '0;
        end else i_d = i_q + 1'b1;
      end
      DRAIN: begin
        if (i_q == L_LAST) begin
          // first O_RD cycle may already carry write 0
          state_d = O_RD;
          i_d     = '0;
          if (ofifo_valid) begin
            owr  = 1'b1;
            widx = '0;
            i_d  = IW'(1);
          end
        end else i_d = i_q + 1'b1;
      end
      O_RD: begin
        // i_q counts writes already shown on inst, including this cycle's
        if (i_q == A_CNT) begin
          i_d = '0;
          if (k_q == K_LAST) begin
            state_d = ACC;
            k_d     = '0;
          end else begin
            state_d = W_XFER;
            k_d     = k_q + 1'b1;
          end
        end else if (ofifo_valid) begin
          owr  = 1'b1;
          widx = i_q;
          i_d  = i_q + 1'b1;
        end
      end
      ACC: begin
        // k is the inner (kij) index, i the outer (output) index
        if (k_q == K_LAST) begin
          k_d = '0;
          if (i_q == A_LAST) begin
            state_d = DONE;
            i_d     = '0;
          end else i_d = i_q + 1'b1;
        end else k_d = k_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
        i_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        i_d     = '0;
      end
    endcase
  end

  // Output logic: instruction word for the cycle being entered
  always_comb begin
    inst_d     = IDLE_WORD;
    inst_d[2]  = ~inst_q[19];               // l0_wr trails each xmem read
    inst_d[33] = ~inst_q[32] & inst_q[31];  // acc trails each pmem read
    if (state_d != IDLE && state_d != DONE) inst_d[7] = mode_d;
    case (state_d)
      W_XFER: begin
        inst_d[19]   = 1'b0;
        inst_d[17:8] = 10'(512 + 32'(k_d) * row + 32'(i_d));
      end
      W_LOAD: begin
        if (i_d < ROW_N) begin
          inst_d[3] = 1'b1;
          inst_d[0] = 1'b1;
        end
      end
      A_XFER: begin
        inst_d[19]   = 1'b0;
        inst_d[17:8] = 10'(32'(k_d) * ACT_LEN + 32'(i_d));
      end
      EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      O_RD: begin
        if (owr) begin
          inst_d[6]     = 1'b1;
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = 11'(32'(k_d) * ACT_LEN + 32'(widx));
        end
      end
      ACC: begin
        inst_d[32]    = 1'b0;
        inst_d[30:20] = 11'(32'(k_d) * ACT_LEN + 32'(i_d));
      end
      default: ;
    endcase
  end

  assign inst = inst_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl with default parameters. Outputs are
// sampled 1 time unit after each rising edge; inputs are changed at the same
// point so they are stable for the next edge.
module tb_corelet_ctrl;

  localparam int ROW = 8, COL = 8, ACT_LEN = 16, NKIJ = 9;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic        clk, reset, start, mode, ofifo_valid;
  logic [33:0] inst;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // values present just before the most recent edge
  logic prv_xrd, prv_prd, prv_valid, prv_done;

  corelet_ctrl #(.row(ROW), .col(COL), .ACT_LEN(ACT_LEN), .NKIJ(NKIJ)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    prv_xrd   = ~inst[19];
    prv_prd   = ~inst[32] & inst[31];
    prv_valid = ofifo_valid;
    prv_done  = done;
    @(posedge clk);
    #1;
  endtask

  // Runs from the current busy cycle (index n0) until the cycle after done.
  task automatic run_to_done(input int n0, input int pulse_cyc, input bit pulse_done,
                             input bit toggle, input logic mode_exp,
                             output int nwr, output int ndone);
    int nrd;
    bit fin;
    nwr = 0; ndone = 0; nrd = 0; fin = 0;
    for (int n = n0; n < n0 + 3000 && !fin; n++) begin
      chk("l0_wr_lag", inst[2], prv_xrd);
      chk("acc_lag", inst[33], prv_prd);
      if (inst[6]) chk("ofifo_rd_after_valid", prv_valid, 1);
      if (!inst[32] && !inst[31]) begin
        chk("ofifo_rd_with_wr", inst[6], 1);
        chk("pmem_wr_addr", inst[30:20], nwr);
        nwr++;
      end
      if (!inst[32] && inst[31]) begin
        chk("acc_rd_addr", inst[30:20], (nrd % NKIJ) * ACT_LEN + nrd / NKIJ);
        nrd++;
      end
      if (busy && !done) chk("mode_sel", inst[7], mode_exp);
      if (done) begin
        ndone++;
        chk("busy_in_done", busy, 1);
        chk("mode_sel_done", inst[7], 0);
      end
      if (prv_done && !done) begin
        chk("busy_falls_with_done", busy, 0);
        chk("idle_word_after_done", inst, IDLE_WORD);
        fin = 1;
      end
      if (!fin) begin
        start       = (n == pulse_cyc) || (pulse_done && done);
        ofifo_valid = toggle ? ~ofifo_valid : 1'b1;
        tick();
      end
    end
    start       = 1'b0;
    ofifo_valid = 1'b1;
    chk("run_finished", fin, 1);
    chk("acc_read_count", nrd, NKIJ * ACT_LEN);
  endtask

  initial begin
    int nwr, nd;
    reset = 1'b1; start = 1'b1; mode = 1'b1; ofifo_valid = 1'b1;
    prv_xrd = 0; prv_prd = 0; prv_valid = 1; prv_done = 0;

    // reset wins over a start presented at the same time
    tick(); tick();
    chk("reset_inst", inst, IDLE_WORD);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    tick();
    chk("idle_no_start_busy", busy, 0);
    chk("idle_inst", inst, IDLE_WORD);

    // WS run: weight-transfer addresses and l0_wr alignment, then whole run
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int j = 0; j < ROW; j++) begin
      chk("w_xfer_addr", inst[17:8], 512 + j);
      chk("w_xfer_cen", inst[19], 0);
      chk("w_xfer_wen", inst[18], 1);
      chk("w_xfer_l0_wr", inst[2], j > 0);
      tick();
    end
    chk("w_load_l0_wr_tail", inst[2], 1);
    chk("w_load_load", inst[0], 1);
    chk("w_load_l0_rd", inst[3], 1);
    chk("w_load_cen_xmem", inst[19], 1);
    run_to_done(ROW + 1, 0, 0, 0, 1'b0, nwr, nd);
    chk("ws_writes", nwr, NKIJ * ACT_LEN);
    chk("ws_done_pulses", nd, 1);

    // OS run: mode bit carried through the run
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    run_to_done(1, 0, 0, 0, 1'b1, nwr, nd);
    chk("os_writes", nwr, NKIJ * ACT_LEN);
    chk("os_done_pulses", nd, 1);

    // ofifo_valid alternating every cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1, 0, 0, 1, 1'b0, nwr, nd);
    chk("toggle_writes", nwr, NKIJ * ACT_LEN);
    chk("toggle_done_pulses", nd, 1);

    // reset in EXEC of the first pass, then restart from kij 0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j < 45; j++) tick();
    chk("exec_l0_rd", inst[3], 1);
    chk("exec_execute", inst[1], 1);
    reset = 1'b1;
    tick();
    chk("midrun_reset_inst", inst, IDLE_WORD);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_addr", inst[17:8], 512);
    chk("restart_cen", inst[19], 0);
    chk("restart_l0_wr", inst[2], 0);
    run_to_done(1, 0, 0, 0, 1'b0, nwr, nd);
    chk("restart_writes", nwr, NKIJ * ACT_LEN);

    // start pulses in DRAIN (cycle 60 of pass 0) and during done are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1, 60, 1, 0, 1'b0, nwr, nd);
    chk("ignored_start_writes", nwr, NKIJ * ACT_LEN);
    chk("ignored_start_done", nd, 1);
    tick();
    chk("start_at_done_ignored", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_after_idle_busy", busy, 1);
    chk("start_after_idle_addr", inst[17:8], 512);
    run_to_done(1, 0, 0, 0, 1'b0, nwr, nd);
    chk("final_writes", nwr, NKIJ * ACT_LEN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
